// File: rtl/dnn_unpack_pkg.sv
// Shared types for the FIFO word unpacker: FSM state encoding and slice-index sizing.
package dnn_unpack_pkg;

    typedef enum logic {
        UNPACK_IDLE   = 1'b0,
        UNPACK_STREAM = 1'b1
    } unpack_state_e;

    // A one-bit counter is kept even for degenerate ratios so the index never has zero width.
    function automatic int slice_idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/unpack_slice_mux.sv
// Combinational RATIO:1 slice selector for the word unpacker.
// Slice order is LSB first unless UNPACK_MSB_FIRST_EN is defined (then MSB first).
module unpack_slice_mux #(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 64,
    parameter int RATIO     = IN_WIDTH / OUT_WIDTH,
    parameter int IDX_W     = 3
) (
    input  logic [IN_WIDTH-1:0]  i_word,
    input  logic [IDX_W-1:0]     i_idx,
    output logic [OUT_WIDTH-1:0] o_slice
);

    logic [31:0] w_sel;

`ifdef UNPACK_MSB_FIRST_EN
    assign w_sel = 32'(RATIO - 1) - 32'(i_idx);
`else
    assign w_sel = 32'(i_idx);
`endif

    assign o_slice = i_word[w_sel*OUT_WIDTH +: OUT_WIDTH];

endmodule

// File: rtl/fifo_word_unpacker.sv
// Pops wide words from a show-ahead FIFO and streams them out as OUT_WIDTH slices.
// Slice ordering is selected by UNPACK_MSB_FIRST_EN inside unpack_slice_mux.
module fifo_word_unpacker
    import dnn_unpack_pkg::*;
#(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic [IN_WIDTH-1:0]  fifo_q,
    input  logic                 fifo_empty,
    output logic                 fifo_rdreq,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = slice_idx_width(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    unpack_state_e        r_state;
    unpack_state_e        w_next_state;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_next_idx;
    logic [IN_WIDTH-1:0]  r_hold;
    logic                 w_at_last;
    logic                 w_xfer;
    logic                 w_rdreq;

    assign w_at_last = (r_idx == LAST_IDX);
    assign w_xfer    = (r_state == UNPACK_STREAM) && out_ready;

    // Popping on the final accepted slice is what keeps consecutive words bubble-free.
    assign w_rdreq = reset_n && !flush && !fifo_empty &&
                     ((r_state == UNPACK_IDLE) ||
                      ((r_state == UNPACK_STREAM) && w_at_last && out_ready));

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        if (flush) begin
            w_next_state = UNPACK_IDLE;
            w_next_idx   = '0;
        end else if (w_rdreq) begin
            w_next_state = UNPACK_STREAM;
            w_next_idx   = '0;
        end else if (w_xfer) begin
            if (w_at_last) begin
                w_next_state = UNPACK_IDLE;
                w_next_idx   = '0;
            end else begin
                w_next_idx = r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= UNPACK_IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            if (w_rdreq) begin
                r_hold <= fifo_q;
            end
        end
    end

    unpack_slice_mux #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .RATIO     (RATIO),
        .IDX_W     (IDX_W)
    ) u_slice_mux (
        .i_word  (r_hold),
        .i_idx   (r_idx),
        .o_slice (out_data)
    );

    assign fifo_rdreq = w_rdreq;
    assign out_valid  = (r_state == UNPACK_STREAM);
    assign out_last   = out_valid && w_at_last;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Randomized bench for fifo_word_unpacker: a queue-based FIFO plus an expected-slice queue model.
module tb_fifo_word_unpacker;

    localparam int IN_W  = 512;
    localparam int OUT_W = 64;
    localparam int RATIO = IN_W / OUT_W;

    logic              clock      = 1'b0;
    logic              reset_n    = 1'b0;
    logic              flush      = 1'b0;
    logic [IN_W-1:0]   fifo_q     = '0;
    logic              fifo_empty = 1'b1;
    logic              out_ready  = 1'b0;
    logic              fifo_rdreq;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_last;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } slice_t;

    logic [IN_W-1:0] fifoQ[$];
    slice_t          expQ[$];
    int              checks = 0;
    int              errors = 0;
    int              cycleNo = 0;
    int              validSeen = 0;
    int              rdCycles[$];

    always #5 clock = ~clock;

    fifo_word_unpacker #(
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A popped word becomes RATIO expected slices in emission order.
    function automatic void pushSlices(input logic [IN_W-1:0] w);
        for (int k = 0; k < RATIO; k++) begin
            slice_t s;
            int     pos;
`ifdef UNPACK_MSB_FIRST_EN
            pos = RATIO - 1 - k;
`else
            pos = k;
`endif
            s.data = w[pos*OUT_W +: OUT_W];
            s.last = (k == RATIO - 1);
            expQ.push_back(s);
        end
    endfunction

    task automatic driveFifo();
        fifo_empty = (fifoQ.size() == 0);
        fifo_q     = fifo_empty ? {16{$urandom()}} : fifoQ[0];
    endtask

    function automatic logic [IN_W-1:0] randWord();
        logic [IN_W-1:0] w;
        for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // One clock cycle: drive after the falling edge, check, then advance the model on the rising edge.
    task automatic applyStimulus(input logic rdy, input logic fl);
        logic            expValid;
        logic            expRd;
        logic            dutRd;
        logic [IN_W-1:0] head;
        out_ready = rdy;
        flush     = fl;
        driveFifo();
        #1;
        expValid = (expQ.size() != 0);
        expRd    = !fl && (fifoQ.size() != 0) && (!expValid || (expQ.size() == 1 && rdy));
        checkOutput("valid", 64'(out_valid), 64'(expValid));
        checkOutput("rdreq", 64'(fifo_rdreq), 64'(expRd));
        if (expValid) begin
            checkOutput("data", out_data, expQ[0].data);
            checkOutput("last", 64'(out_last), 64'(expQ[0].last));
        end else begin
            checkOutput("last_idle", 64'(out_last), 64'(0));
        end
        if (out_valid) validSeen++;
        if (fifo_rdreq) rdCycles.push_back(cycleNo);
        dutRd = fifo_rdreq;
        head  = fifo_q;
        @(posedge clock);
        if (dutRd && fifoQ.size() != 0) void'(fifoQ.pop_front());
        if (fl) expQ.delete();
        else if (expValid && rdy) void'(expQ.pop_front());
        if (expRd) pushSlices(head);
        cycleNo++;
        @(negedge clock);
    endtask

    initial begin
        logic [IN_W-1:0] w;
        int              n;

        $display("[TB] reset and idle");
        @(negedge clock);
        #1;
        checkOutput("rst_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_last", 64'(out_last), 64'(0));
        checkOutput("rst_data", out_data, 64'(0));
        checkOutput("rst_rdreq", 64'(fifo_rdreq), 64'(0));
        fifo_empty = 1'b0;
        fifo_q     = randWord();
        #1;
        checkOutput("rst_rdreq_nonempty", 64'(fifo_rdreq), 64'(0));
        fifo_empty = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);

        $display("[TB] single word");
        for (int k = 0; k < RATIO; k++) w[k*OUT_W +: OUT_W] = 64'hA000_0000_0000_0000 | 64'(k);
        fifoQ.push_back(w);
        for (int i = 0; i < RATIO + 3; i++) applyStimulus(1'b1, 1'b0);

        $display("[TB] back-to-back");
        for (int i = 0; i < 4; i++) fifoQ.push_back(randWord());
        validSeen = 0;
        rdCycles.delete();
        for (int i = 0; i < 4 * RATIO + 2; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("btb_valid_cycles", 64'(validSeen), 64'(4 * RATIO));
        checkOutput("btb_rdreq_count", 64'(rdCycles.size()), 64'(4));
        for (int i = 1; i < rdCycles.size(); i++)
            checkOutput("btb_rdreq_spacing", 64'(rdCycles[i] - rdCycles[i-1]), 64'(RATIO));

        $display("[TB] backpressure");
        for (int i = 0; i < 5; i++) fifoQ.push_back(randWord());
        n = 0;
        while (expQ.size() != 1 && n < 200) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
        checkOutput("bp_reach_last", 64'(expQ.size()), 64'(1));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        n = 0;
        while ((expQ.size() != 0 || fifoQ.size() != 0) && n < 400) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
        checkOutput("bp_drained", 64'(expQ.size() + fifoQ.size()), 64'(0));

        $display("[TB] flush");
        for (int i = 0; i < 2; i++) fifoQ.push_back(randWord());
        n = 0;
        while (expQ.size() != RATIO - 3 && n < 20) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        checkOutput("flush_reach_idx3", 64'(expQ.size()), 64'(RATIO - 3));
        applyStimulus(1'b1, 1'b1);
        n = 0;
        while ((expQ.size() != 0 || fifoQ.size() != 0) && n < 40) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        checkOutput("flush_drained", 64'(expQ.size() + fifoQ.size()), 64'(0));
        applyStimulus(1'b1, 1'b0);

        $display("[TB] reset mid-word");
        fifoQ.push_back(randWord());
        n = 0;
        while (expQ.size() != RATIO - 2 && n < 20) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(out_valid), 64'(0));
        checkOutput("midrst_data", out_data, 64'(0));
        checkOutput("midrst_rdreq", 64'(fifo_rdreq), 64'(0));
        expQ.delete();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_word_unpacker.md
# fifo_word_unpacker

Downstream consumer of the soft FIFO in the dnnweaver data path: pops IN_WIDTH-bit words from the FIFO's show-ahead read port and serializes each into IN_WIDTH/OUT_WIDTH narrow slices on a valid/ready stream toward the PE array. It sustains one slice per cycle with no bubble between consecutive FIFO words. It also supports a synchronous flush that discards the partially consumed word.

## Interface
Parameters:
- IN_WIDTH, 512, FIFO word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 64, output slice width.
- RATIO (localparam), IN_WIDTH/OUT_WIDTH; must be ≥2. The slice counter is $clog2(RATIO) bits wide.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops the held word and returns to IDLE.
- fifo_q  in  IN_WIDTH  FIFO head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdreq  out  1  FIFO dequeue; combinational.
- out_data  out  OUT_WIDTH  current slice.
- out_valid  out  1  slice valid.
- out_last  out  1  high with the final slice of a word.
- out_ready  in  1  downstream accept.

## Operation
- State machine with two states: IDLE (no word held) and STREAM (word held in hold_reg, slice index idx).
- Transfer rule: a slice transfers when out_valid && out_ready.
- fifo_rdreq = reset_n && !flush && !fifo_empty && (IDLE || (STREAM && idx==RATIO-1 && out_ready)).
- When fifo_rdreq=1, the next edge loads hold_reg ← fifo_q, sets idx ← 0 and state ← STREAM.
- IDLE with fifo_empty=1: stay in IDLE.
- STREAM with a transfer and idx<RATIO-1: idx ← idx+1.
- STREAM with a transfer and idx==RATIO-1:
  - if the FIFO is non-empty, load the next word (no bubble);
  - otherwise go to IDLE.
- STREAM with out_ready=0: hold everything. out_data and out_valid must stay stable.
- out_valid is high exactly when state==STREAM.
- out_last = out_valid && idx==RATIO-1.
- out_data = hold_reg[idx*OUT_WIDTH +: OUT_WIDTH], so slice 0 is the LSBs (default order).
- flush has priority over all other events: the next edge goes to IDLE with idx=0, and no dequeue happens that cycle. A transfer presented in the flush cycle is still seen downstream, but the remaining slices are lost.
- The block never asserts fifo_rdreq while fifo_empty=1, so FIFO underflow is impossible.

## Timing
- Reset (asynchronous assert): state=IDLE, idx=0, hold_reg=0. Outputs: out_valid=0, out_last=0, out_data=0, fifo_rdreq=0.
- Reset deassertion is synchronized externally. The first rdreq can occur in the first cycle after release.
- Latency: fifo_empty falls in cycle N while IDLE, so rdreq is high in cycle N and slice 0 is valid in cycle N+1.
- Throughput: with out_ready held high and the FIFO never empty, out_valid stays continuously high and one word is popped every RATIO cycles.
- Reset asserted mid-word: the held word is discarded. The FIFO is not rewound.

## Configuration
- UNPACK_MSB_FIRST_EN:
  - When defined, slice idx maps to hold_reg[(RATIO-1-idx)*OUT_WIDTH +: OUT_WIDTH], i.e. MSB slice first.
  - When undefined, the order is LSB first.
- out_last, the handshake, and the timing are identical in both cases.

## Structure
- Shared package dnn_unpack_pkg holds the state enum typedef (UNPACK_IDLE, UNPACK_STREAM) and the slice-index width function.
- One sub-module, unpack_slice_mux: a combinational RATIO:1 slice selector that carries the UNPACK_MSB_FIRST_EN ordering.
- The top module holds the FSM, idx counter, hold_reg and rdreq logic.

## Test plan
All scenarios use IN_WIDTH=512 and OUT_WIDTH=64 (RATIO=8).
- **Reset and idle:** reset_n=0, then FIFO empty → all outputs 0 and fifo_rdreq never asserted.
- **Single word:** one word with slice k = 64'hA000_0000_0000_000k, out_ready=1 → slices 0..7 in cycles N+1..N+8, out_last only on 64'hA000_0000_0000_0007, then out_valid=0.
- **Back-to-back:** 4 words preloaded, out_ready=1 → 32 consecutive valid cycles with no gap, and fifo_rdreq pulses exactly every 8 cycles.
- **Backpressure:** out_ready toggled randomly, including low on the last slice with the FIFO non-empty → out_data stable while stalled, no rdreq until the last slice is accepted, and no slice lost or duplicated.
- **Flush:** flush at idx=3 → slices 4..7 dropped, the next FIFO word starts at slice 0 one cycle after flush, and no rdreq occurs in the flush cycle.
- **MSB order:** with UNPACK_MSB_FIRST_EN defined, the single-word case emits 64'hA000_0000_0000_0007 first and ..._0000 last, with out_last on the latter.
